// File: rtl/coin_pkg.sv
// Shared types and constants for the coin tracker.
// Optional build macro: COIN_RESPAWN_EN enables lap-wrap coin respawn in coin_tracker.
package coin_pkg;

  // Number of coins exported by the background block.
  localparam int COIN_NUMBER = 3;

  // Width of the terrain frame counter.
  localparam int FC_W = 12;

  typedef logic [12:0]        coin_x_t;
  typedef logic [9:0]         coin_y_t;
  typedef logic signed [13:0] coin_dist_t;
  typedef logic [FC_W-1:0]    frame_cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } coin_state_e;

  // 8-bit add that clamps at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/coin_hit_check.sv
// Combinational hitbox test for one coin against the stickman.
// Shared by all scan cycles; the caller selects which coin is presented.
module coin_hit_check
  import coin_pkg::*;
#(
  parameter int STICKMAN_X = 120,
  parameter int HIT_HALF_W = 30,
  parameter int HIT_HALF_H = 50
) (
  input  logic       present_i,
  input  coin_x_t    coin_x_i,
  input  coin_y_t    coin_y_i,
  input  frame_cnt_t fc_snap_i,
  input  coin_y_t    stickman_y_i,
  output logic       hit_o
);

  localparam coin_dist_t W_MAX = coin_dist_t'(HIT_HALF_W);
  localparam coin_dist_t W_MIN = -W_MAX;
  localparam coin_dist_t H_MAX = coin_dist_t'(HIT_HALF_H);
  localparam coin_dist_t H_MIN = -H_MAX;

  coin_dist_t sx;
  coin_dist_t dx;
  coin_dist_t dy;
  logic       in_x;
  logic       in_y;

  // Screen X of the coin may go negative (off-screen left); the signed
  // compare still evaluates it and simply reports no overlap.
  assign sx = coin_dist_t'({1'b0, coin_x_i}) - coin_dist_t'({2'b00, fc_snap_i});
  assign dx = sx - coin_dist_t'(STICKMAN_X);
  assign dy = coin_dist_t'({4'b0000, coin_y_i}) - coin_dist_t'({4'b0000, stickman_y_i});

  assign in_x  = (dx <= W_MAX) && (dx >= W_MIN);
  assign in_y  = (dy <= H_MAX) && (dy >= H_MIN);
  assign hit_o = present_i & in_x & in_y;

endmodule

// File: rtl/coin_tracker.sv
// Per-frame coin collection: scans each coin against the stickman hitbox,
// clears touched coins, keeps a saturating score and strobes coin_pulse.
// Optional build macro: COIN_RESPAWN_EN (coins reappear when frame_counter wraps).
module coin_tracker #(
  parameter int COIN_NUMBER = 3,
  parameter int STICKMAN_X  = 120,
  parameter int HIT_HALF_W  = 30,
  parameter int HIT_HALF_H  = 50
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   playing,
  input  logic [11:0]            frame_counter,
  input  logic [12:0]            CoinFrameX [COIN_NUMBER],
  input  logic [9:0]             CoinY      [COIN_NUMBER],
  input  logic [9:0]             StickmanY,
  output logic [COIN_NUMBER-1:0] CoinStatus,
  output logic [7:0]             score,
  output logic                   coin_pulse
);

  import coin_pkg::*;

  localparam int IDX_W = (COIN_NUMBER > 1) ? $clog2(COIN_NUMBER) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COIN_NUMBER - 1);

  coin_state_e            state_q,       state_d;
  logic [IDX_W-1:0]       idx_q,         idx_d;
  frame_cnt_t             fc_snap_q,     fc_snap_d;
  logic [COIN_NUMBER-1:0] hit_vec_q,     hit_vec_d;
  logic [COIN_NUMBER-1:0] coin_status_q, coin_status_d;
  logic [7:0]             score_q,       score_d;
  logic                   coin_pulse_q,  coin_pulse_d;
  logic                   frame_clk_q;
  logic                   playing_q;

  logic                   frame_edge;
  logic                   playing_rise;
  logic                   wrap;
  frame_cnt_t             fc_cur;
  coin_x_t                sel_x;
  coin_y_t                sel_y;
  logic                   sel_present;
  logic                   cur_hit;
  logic [7:0]             hit_cnt;

`ifdef COIN_RESPAWN_EN
  frame_cnt_t             fc_last_q,     fc_last_d;
  assign wrap = (fc_snap_q < fc_last_q);
`else
  assign wrap = 1'b0;
`endif

  assign frame_edge   = frame_clk & ~frame_clk_q;
  assign playing_rise = playing & ~playing_q;

  // The first scan cycle uses the live counter (it is being snapshotted in
  // that same cycle); later scan cycles use the held snapshot.
  assign fc_cur = (idx_q == '0) ? frame_counter : fc_snap_q;

  // Present the coin addressed by idx to the single shared hit checker.
  always_comb begin
    sel_x       = '0;
    sel_y       = '0;
    sel_present = 1'b0;
    for (int i = 0; i < COIN_NUMBER; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_x       = CoinFrameX[i];
        sel_y       = CoinY[i];
        sel_present = coin_status_q[i];
      end
    end
  end

  coin_hit_check #(
    .STICKMAN_X (STICKMAN_X),
    .HIT_HALF_W (HIT_HALF_W),
    .HIT_HALF_H (HIT_HALF_H)
  ) u_hit_check (
    .present_i    (sel_present),
    .coin_x_i     (sel_x),
    .coin_y_i     (sel_y),
    .fc_snap_i    (fc_cur),
    .stickman_y_i (StickmanY),
    .hit_o        (cur_hit)
  );

  // Count coins collected in the frame being committed.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < COIN_NUMBER; i++) begin
      hit_cnt = hit_cnt + 8'(hit_vec_q[i]);
    end
  end

  // Next-state and datapath updates; defaults hold everything and keep the pulse low.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fc_snap_d     = fc_snap_q;
    hit_vec_d     = hit_vec_q;
    coin_status_d = coin_status_q;
    score_d       = score_q;
    coin_pulse_d  = 1'b0;
`ifdef COIN_RESPAWN_EN
    fc_last_d     = fc_last_q;
`endif

    if (!playing) begin
      // Game over: park the FSM and restore coins, but leave the score visible.
      state_d       = IDLE;
      idx_d         = '0;
      hit_vec_d     = '0;
      coin_status_d = '1;
`ifdef COIN_RESPAWN_EN
      fc_last_d     = '0;
`endif
    end else begin
      if (playing_rise) begin
        score_d = '0;
      end

      unique case (state_q)
        IDLE: begin
          // Edges seen in other states are intentionally ignored.
          if (frame_edge) begin
            state_d   = SCAN;
            idx_d     = '0;
            hit_vec_d = '0;
          end
        end

        SCAN: begin
          if (idx_q == '0) begin
            fc_snap_d = frame_counter;
          end
          for (int i = 0; i < COIN_NUMBER; i++) begin
            if (idx_q == IDX_W'(i)) begin
              hit_vec_d[i] = cur_hit;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = COMMIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end

        COMMIT: begin
          coin_status_d = (wrap ? {COIN_NUMBER{1'b1}} : coin_status_q) & ~hit_vec_q;
          score_d       = sat_add8(score_q, hit_cnt);
          coin_pulse_d  = |hit_vec_q;
`ifdef COIN_RESPAWN_EN
          fc_last_d     = fc_snap_q;
`endif
          state_d       = IDLE;
        end

        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State registers; asynchronous reset aborts any scan in progress.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      fc_snap_q     <= '0;
      hit_vec_q     <= '0;
      coin_status_q <= '1;
      score_q       <= '0;
      coin_pulse_q  <= 1'b0;
      frame_clk_q   <= 1'b0;
      playing_q     <= 1'b0;
`ifdef COIN_RESPAWN_EN
      fc_last_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fc_snap_q     <= fc_snap_d;
      hit_vec_q     <= hit_vec_d;
      coin_status_q <= coin_status_d;
      score_q       <= score_d;
      coin_pulse_q  <= coin_pulse_d;
      frame_clk_q   <= frame_clk;
      playing_q     <= playing;
`ifdef COIN_RESPAWN_EN
      fc_last_q     <= fc_last_d;
`endif
    end
  end

  assign CoinStatus = coin_status_q;
  assign score      = score_q;
  assign coin_pulse = coin_pulse_q;

endmodule

// File: tb/tb_coin_tracker.sv
// Self-checking bench for coin_tracker: directed vector table, hand-written
// multi-cycle sequences and randomized frames checked against a reference model.
// Honours COIN_RESPAWN_EN the same way as the design.
module tb_coin_tracker;

`ifdef COIN_RESPAWN_EN
  localparam bit RESPAWN = 1'b1;
`else
  localparam bit RESPAWN = 1'b0;
`endif

  localparam int FAR_X = 5000;
  localparam int FAR_Y = 600;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic        playing;
  logic [11:0] frame_counter;
  logic [12:0] coin_x [3];
  logic [9:0]  coin_y [3];
  logic [9:0]  stick_y;
  logic [2:0]  CoinStatus;
  logic [7:0]  score;
  logic        coin_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [2:0] m_status;
  int         m_score;
  int         m_last;

  typedef struct {
    string name;
    int    fc;
    int    x0, y0, x1, y1, x2, y2;
    int    es;
    int    esc;
    int    ep;
  } vec_t;

  vec_t vecs[$];

  coin_tracker dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_clk     (frame_clk),
    .playing       (playing),
    .frame_counter (frame_counter),
    .CoinFrameX    (coin_x),
    .CoinY         (coin_y),
    .StickmanY     (stick_y),
    .CoinStatus    (CoinStatus),
    .score         (score),
    .coin_pulse    (coin_pulse)
  );

  always #10 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input string n, input int fc,
                                  input int x0, input int y0, input int x1, input int y1,
                                  input int x2, input int y2,
                                  input int es, input int esc, input int ep);
    vec_t v;
    v.name = n; v.fc = fc;
    v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
    v.es = es; v.esc = esc; v.ep = ep;
    vecs.push_back(v);
  endfunction

  task automatic place(input int fc, input int x0, input int y0, input int x1, input int y1,
                       input int x2, input int y2);
    frame_counter = 12'(fc);
    coin_x[0] = 13'(x0); coin_y[0] = 10'(y0);
    coin_x[1] = 13'(x1); coin_y[1] = 10'(y1);
    coin_x[2] = 13'(x2); coin_y[2] = 10'(y2);
  endtask

  // Apply one frame of the game rules to the model using the current inputs.
  task automatic model_frame(output logic [2:0] es, output int esc, output bit ep);
    int         n;
    int         dx;
    int         dy;
    logic [2:0] hits;
    n = 0;
    hits = '0;
    for (int i = 0; i < 3; i++) begin
      dx = int'(coin_x[i]) - int'(frame_counter) - 120;
      dy = int'(coin_y[i]) - int'(stick_y);
      if (m_status[i] && dx <= 30 && dx >= -30 && dy <= 50 && dy >= -50) begin
        hits[i] = 1'b1;
        n++;
      end
    end
    if (RESPAWN && int'(frame_counter) < m_last) m_status = 3'b111;
    m_status = m_status & ~hits;
    m_last   = int'(frame_counter);
    m_score  = (m_score + n > 255) ? 255 : m_score + n;
    es  = m_status;
    esc = m_score;
    ep  = (n > 0);
  endtask

  // One frame strobe; outputs are checked 5 cycles after the edge cycle and the
  // pulse must be absent in every other cycle of the window.
  task automatic run_frame(input string name, input int es, input int esc, input int ep);
    int         stray;
    logic [2:0] st_s;
    int         sc_s;
    int         p_s;
    stray = 0; st_s = '0; sc_s = 0; p_s = 0;
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clk); #1;
      if (k == 1) frame_clk = 1'b0;
      if (k == 5) begin
        st_s = CoinStatus;
        sc_s = int'(score);
        p_s  = int'(coin_pulse);
      end else if (coin_pulse) begin
        stray++;
      end
    end
    $display("frame %s: fc=%0d status=%b score=%0d pulse=%0d", name, frame_counter, st_s, sc_s, p_s);
    chk({name, "/status"}, int'(st_s), es);
    chk({name, "/score"}, sc_s, esc);
    chk({name, "/pulse"}, p_s, ep);
    chk({name, "/stray_pulse"}, stray, 0);
  endtask

  task automatic model_and_run(input string name);
    logic [2:0] es;
    int         esc;
    bit         ep;
    model_frame(es, esc, ep);
    run_frame(name, int'(es), esc, int'(ep));
  endtask

  // Drop and re-raise playing: coins restore, score holds, then clears on the rise.
  task automatic restart();
    @(posedge Clk); #1;
    playing = 1'b0;
    @(posedge Clk); #1;
    chk("drop/score_hold", int'(score), m_score);
    chk("drop/status", int'(CoinStatus), 7);
    playing = 1'b1;
    @(posedge Clk); #1;
    chk("rise/score_clear", int'(score), 0);
    m_status = 3'b111;
    m_score  = 0;
    m_last   = 0;
  endtask

  initial begin
    logic [2:0] es;
    int         esc;
    bit         ep;
    int         pulses;
    int         base;

    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    playing   = 1'b0;
    stick_y   = 10'd200;
    place(0, FAR_X, FAR_Y, FAR_X, FAR_Y, FAR_X, FAR_Y);
    m_status = 3'b111; m_score = 0; m_last = 0;

    repeat (3) @(posedge Clk);
    #1;
    chk("reset/status", int'(CoinStatus), 7);
    chk("reset/score", int'(score), 0);
    chk("reset/pulse", int'(coin_pulse), 0);
    Reset_n = 1'b1;
    playing = 1'b1;
    @(posedge Clk); #1;

    // name, fc, x0,y0, x1,y1, x2,y2, status, score, pulse (fresh game each)
    add_vec("no_overlap", 0,    FAR_X, FAR_Y, FAR_X, FAR_Y, FAR_X, FAR_Y, 7, 0, 0);
    add_vec("coin1_hit",  980,  FAR_X, FAR_Y, 1100, 180,    FAR_X, FAR_Y, 5, 1, 1);
    add_vec("dx_p30",     100,  250, 200,     FAR_X, FAR_Y, FAR_X, FAR_Y, 6, 1, 1);
    add_vec("dx_p31",     100,  251, 200,     FAR_X, FAR_Y, FAR_X, FAR_Y, 7, 0, 0);
    add_vec("dx_m30",     100,  190, 200,     FAR_X, FAR_Y, FAR_X, FAR_Y, 6, 1, 1);
    add_vec("dx_m31",     100,  189, 200,     FAR_X, FAR_Y, FAR_X, FAR_Y, 7, 0, 0);
    add_vec("dy_m50",     100,  220, 150,     FAR_X, FAR_Y, FAR_X, FAR_Y, 6, 1, 1);
    add_vec("dy_m51",     100,  220, 149,     FAR_X, FAR_Y, FAR_X, FAR_Y, 7, 0, 0);
    add_vec("dy_p50",     100,  FAR_X, FAR_Y, FAR_X, FAR_Y, 220, 250,     3, 1, 1);
    add_vec("two_coins",  100,  220, 200,     FAR_X, FAR_Y, 220, 210,     2, 2, 1);
    add_vec("off_left",   4000, 10, 200,      FAR_X, FAR_Y, FAR_X, FAR_Y, 7, 0, 0);
    add_vec("three",      100,  220, 200,     215, 230,     240, 170,     0, 3, 1);

    for (int v = 0; v < vecs.size(); v++) begin
      restart();
      place(vecs[v].fc, vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].x2, vecs[v].y2);
      model_frame(es, esc, ep);
      run_frame(vecs[v].name, vecs[v].es, vecs[v].esc, vecs[v].ep);
    end

    // Second frame in the same game accumulates onto the existing score.
    restart();
    place(980, FAR_X, FAR_Y, 1100, 180, FAR_X, FAR_Y);
    model_frame(es, esc, ep);
    run_frame("accum_a", 5, 1, 1);
    place(980, 1100, 200, 1100, 180, FAR_X, FAR_Y);
    model_frame(es, esc, ep);
    run_frame("accum_b", 4, 2, 1);

    // Lap wrap after collecting coin 0.
    restart();
    place(3094, 3214, 200, FAR_X, FAR_Y, FAR_X, FAR_Y);
    model_frame(es, esc, ep);
    run_frame("wrap_collect", 6, 1, 1);
    place(0, 8000, 200, FAR_X, FAR_Y, FAR_X, FAR_Y);
    model_frame(es, esc, ep);
    run_frame("wrap_next", RESPAWN ? 7 : 6, 1, 0);

`ifdef COIN_RESPAWN_EN
    // Drive the score up to saturation across laps.
    restart();
    while (m_score < 252) begin
      place(100, 220, 200, 220, 200, 220, 200);
      model_and_run("sat_hit3");
      place(0, 220, 200, 220, 200, 220, 200);
      model_and_run("sat_lap");
    end
    place(100, 220, 200, 220, 200, FAR_X, FAR_Y);
    model_and_run("sat_to254");
    chk("sat/score254", int'(score), 254);
    place(0, 220, 200, 220, 200, FAR_X, FAR_Y);
    model_and_run("sat_lap2");
    place(100, 220, 200, 220, 200, FAR_X, FAR_Y);
    model_and_run("sat_to255");
    chk("sat/score255", int'(score), 255);
`endif

    // Reset in the middle of a scan: immediate reset values, no commit afterwards.
    restart();
    place(980, FAR_X, FAR_Y, 1100, 180, FAR_X, FAR_Y);
    model_and_run("pre_reset");
    place(100, 220, 200, 1100, 180, FAR_X, FAR_Y);
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    frame_clk = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    chk("midscan_reset/status", int'(CoinStatus), 7);
    chk("midscan_reset/score", int'(score), 0);
    chk("midscan_reset/pulse", int'(coin_pulse), 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    m_status = 3'b111; m_score = 0; m_last = 0;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge Clk); #1;
      if (coin_pulse) pulses++;
    end
    $display("midscan_reset: status=%b score=%0d pulses=%0d", CoinStatus, score, pulses);
    chk("midscan_reset/no_commit_status", int'(CoinStatus), 7);
    chk("midscan_reset/no_commit_score", int'(score), 0);
    chk("midscan_reset/no_commit_pulse", pulses, 0);

    // Randomized frames near the hitbox.
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 9) == 0) restart();
      base    = int'($urandom_range(0, 3095));
      stick_y = 10'($urandom_range(100, 400));
      frame_counter = 12'(base);
      for (int i = 0; i < 3; i++) begin
        coin_x[i] = 13'(base + 120 + int'($urandom_range(0, 80)) - 40);
        coin_y[i] = 10'(int'(stick_y) + int'($urandom_range(0, 140)) - 70);
      end
      model_and_run($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_tracker.md
# coin_tracker

Game-logic side of the coin interface exported by the background block. Once per game frame it scans the three coins and compares each coin's screen position against the stickman hitbox. Touched coins are cleared in `CoinStatus`, which is returned to the background renderer, and a saturating score is accumulated. Coins respawn when the terrain frame counter wraps to a new lap.

## Interface
Parameters:
- `COIN_NUMBER`, 3: coins tracked; must match the background block.
- `STICKMAN_X`, 120: fixed screen X of the stickman centre.
- `HIT_HALF_W`, 30: horizontal hit tolerance (stickman half-width 20 + coin radius 10).
- `HIT_HALF_H`, 50: vertical hit tolerance (stickman half-height 40 + coin radius 10).

Ports:
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: frame strobe, about 60 Hz, synchronous to `Clk`.
- `playing` in 1: game-running status.
- `frame_counter` in 12: terrain scroll offset from the background block.
- `CoinFrameX[COIN_NUMBER]` in 13 each: coin X positions in the frame.
- `CoinY[COIN_NUMBER]` in 10 each: coin centre Y positions on screen.
- `StickmanY` in 10: stickman centre Y on screen.
- `CoinStatus` out `COIN_NUMBER`: bit i = 1 means coin i is present and drawn.
- `score` out 8: coins collected this game, saturating at 255.
- `coin_pulse` out 1: one-cycle strobe when at least one coin was collected this frame.

## Operation
- Frame edge detection: `frame_clk` is registered once; `frame_edge = frame_clk & ~frame_clk_d`.
- FSM states: `IDLE`, `SCAN`, `COMMIT`.
  - `IDLE` → `SCAN`, with `idx = 0`, on `frame_edge` while `playing = 1`.
  - `SCAN` lasts one cycle per coin. `idx` steps 0 → `COIN_NUMBER-1`, and the hit result for coin `idx` goes into the `hit_vec` register.
  - In the first `SCAN` cycle, `frame_counter` is latched into `fc_snap`.
  - `SCAN` → `COMMIT` after `idx = COIN_NUMBER-1`.
  - `COMMIT` → `IDLE` unconditionally.
- Hit arithmetic uses 14-bit signed values:
  - `sx = CoinFrameX[i] - fc_snap`
  - `dx = sx - STICKMAN_X`
  - `dy = CoinY[i] - StickmanY`
  - hit = `CoinStatus[i] & (|dx| <= HIT_HALF_W) & (|dy| <= HIT_HALF_H)`
  - Negative `sx`, i.e. a coin off-screen left, still evaluates normally; with these tolerances it cannot hit.
- Lap wrap: `wrap = (fc_snap < fc_last)`. `fc_last` updates in `COMMIT`.
- `COMMIT` actions:
  - `CoinStatus <= (wrap ? all-ones : CoinStatus) & ~hit_vec`.
  - `score <= min(255, score + popcount(hit_vec))`.
  - `coin_pulse = |hit_vec`.
- Multiple coins hit in the same frame: all are cleared, score increases by the count, and `coin_pulse` fires once.
- A `frame_edge` arriving outside `IDLE` is dropped, never queued.
- `playing = 0`:
  - The FSM is forced to `IDLE` synchronously.
  - `CoinStatus <= all-ones`, `fc_last <= 0`, `hit_vec <= 0`.
  - `score` holds its value so it stays visible after game over.
- Rising edge of `playing`: `score <= 0` in that cycle.

## Timing
- Reset values (`Reset_n = 0`, async):
  - FSM `IDLE`, `idx = 0`.
  - `CoinStatus = all-ones`, `score = 0`, `coin_pulse = 0`.
  - `fc_snap = 0`, `fc_last = 0`, `hit_vec = 0`, `frame_clk_d = 0`, `playing_d = 0`.
- Cycle-level sequence, with `frame_clk` rising at cycle N:
  - `frame_edge` is high in cycle N.
  - `SCAN` occupies cycles N+1 to N+3.
  - `COMMIT` occurs at N+4.
  - `CoinStatus`, `score` and `coin_pulse` are visible at N+5.
- Total latency is 5 `Clk` cycles, far below the frame period.
- The background block's `frame_counter` update lands at N+1, so `fc_snap` samples the new value.
- `coin_pulse` is high for exactly one cycle.
- Reset asserted mid-scan immediately aborts the scan; no partial commit occurs.

## Configuration
- `COIN_RESPAWN_EN` defined: wrap detection is active and all coins reappear each lap.
- `COIN_RESPAWN_EN` undefined: `wrap` is tied to 0 and `fc_last` is not implemented. Collected coins stay cleared until `playing` falls or reset asserts.

## Structure
- Shared package `coin_pkg`:
  - `COIN_NUMBER`.
  - Typedefs `coin_x_t` (13 bits), `coin_y_t` (10 bits), `coin_dist_t` (signed 14 bits).
  - `coin_state_e` enum (`IDLE`, `SCAN`, `COMMIT`).
- One sub-module, `coin_hit_check`: combinational hitbox compare taking `coin_x_t`, `coin_y_t`, `fc_snap` and `StickmanY`, returning the hit bit. It is instantiated once and shared across scan cycles.

## Test plan
- Reset, then `playing = 1` with no coin overlap: `CoinStatus = 3'b111`, `score = 0`, `coin_pulse` never asserts.
- `CoinFrameX[1] = 1100`, `frame_counter = 980`, `CoinY[1] = 180`, `StickmanY = 200`, one frame edge: at N+5 `CoinStatus = 3'b101`, `score = 1`, single-cycle `coin_pulse`.
- Boundary: `dx = 30` hits, `dx = 31` misses; `dy = -50` hits, `dy = -51` misses.
- Two coins placed to overlap in one frame: `CoinStatus` clears both bits, `score` increases by 2, one pulse.
- With `COIN_RESPAWN_EN`, `frame_counter` going 3094 → 0 after collecting coin 0: `CoinStatus` returns to `3'b111`. Without the macro it stays `3'b110`.
- `score = 254` with two coins hit: `score = 255`. Then drop `playing` (`score` holds 255), then raise `playing`: `score = 0`.
- `Reset_n` pulsed low during `SCAN`: outputs go to reset values immediately and no commit follows.
